// File: rtl/drv_display_n_pkg.sv
// Shared constants and the hex glyph table for the multiplexed 7-segment driver.
// Glyph bit order is {g,f,e,d,c,b,a}, active-high.
package drv_display_n_pkg;

   localparam logic [4:0] CODE_BLANK = 5'd16;
   localparam logic [4:0] CODE_DASH  = 5'd17;

   localparam logic [6:0] SEG_BLANK  = 7'b0000000;
   localparam logic [6:0] SEG_DASH   = 7'b1000000;

   // Hexadecimal glyphs 0..F
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'b0111111;
         4'h1:    g = 7'b0000110;
         4'h2:    g = 7'b1011011;
         4'h3:    g = 7'b1001111;
         4'h4:    g = 7'b1100110;
         4'h5:    g = 7'b1101101;
         4'h6:    g = 7'b1111101;
         4'h7:    g = 7'b0000111;
         4'h8:    g = 7'b1111111;
         4'h9:    g = 7'b1101111;
         4'hA:    g = 7'b1110111;
         4'hB:    g = 7'b1111100;
         4'hC:    g = 7'b0111001;
         4'hD:    g = 7'b1011110;
         4'hE:    g = 7'b1111001;
         default: g = 7'b1110001;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/drv_display_n_if.sv
// Bundle between the numeric producer (master) and the display driver (slave).
// There is no handshake: load is a one-cycle capture strobe, blank_lz,
// blink_mask and brightness are levels sampled every cycle, and the display
// outputs are registered and valid on every cycle.
interface drv_display_n_if #(
   parameter int N_DIGITS = 3
);
   logic [5*N_DIGITS-1:0] digits;
   logic [N_DIGITS-1:0]   dp;
   logic                  load;
   logic                  blank_lz;
   logic [N_DIGITS-1:0]   blink_mask;
   logic [3:0]            brightness;
   logic [N_DIGITS-1:0]   enable;
   logic [6:0]            segmentos;
   logic                  dp_out;
   logic                  frame_tick;

   modport master (
      output digits, dp, load, blank_lz, blink_mask, brightness,
      input  enable, segmentos, dp_out, frame_tick
   );

   modport slave (
      input  digits, dp, load, blank_lz, blink_mask, brightness,
      output enable, segmentos, dp_out, frame_tick
   );
endinterface

// File: rtl/drv_display_n_glyph.sv
// Combinational digit-code to segment decoder: 0..15 hex, 17 dash, others blank.
module seg7_glyph
   import drv_display_n_pkg::*;
(
   input  logic [4:0] code_i,
   output logic [6:0] glyph_o
);

   // Codes with bit 4 clear are hex; of the upper half only the dash code lights
   always_comb begin
      glyph_o = SEG_BLANK;
      if (code_i[4] == 1'b0) begin
         glyph_o = hex_glyph(code_i[3:0]);
      end else if (code_i == CODE_DASH) begin
         glyph_o = SEG_DASH;
      end
   end

endmodule

// File: rtl/drv_display_n.sv
// Multiplexed N-digit 7-segment driver: prescaled digit scan, frame-synchronous
// double buffer, leading-zero suppression, per-digit blink and PWM brightness.
module drv_display_n
   import drv_display_n_pkg::*;
#(
   parameter int N_DIGITS     = 3,
   parameter int PRESCALE     = 32,
   parameter int BLINK_FRAMES = 64
) (
   input logic           clk,
   input logic           rst,
   drv_display_n_if.slave bus
);

   localparam int PW = $clog2(PRESCALE);
   localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int CW = 5 * N_DIGITS;

   localparam logic [PW-1:0]       P_LAST  = PW'(PRESCALE - 1);
   localparam logic [SW-1:0]       S_LAST  = SW'(N_DIGITS - 1);
   localparam logic [BW-1:0]       B_LAST  = BW'(BLINK_FRAMES - 1);
   localparam logic [N_DIGITS-1:0] EN_ONE  = N_DIGITS'(1);

   logic [PW-1:0]       p_q;
   logic [SW-1:0]       s_q;
   logic [BW-1:0]       blink_cnt_q;
   logic                phase_q;
   logic                pend_v_q;
   logic [CW-1:0]       pend_codes_q;
   logic [CW-1:0]       act_codes_q;
   logic [N_DIGITS-1:0] pend_dp_q;
   logic [N_DIGITS-1:0] act_dp_q;

   logic [N_DIGITS-1:0] enable_q, enable_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic                tick_q;

   logic                boundary;
   logic [N_DIGITS-1:0] lz_mask;
   logic [4:0]          cur_code;
   logic                cur_dp;
   logic                cur_lz;
   logic                cur_blink;
   logic [6:0]          glyph;

   // Last cycle of the last slot: buffer swap, blink count and frame tick happen here
   assign boundary = (p_q == P_LAST) && (s_q == S_LAST);

   // A digit is suppressed while it and every digit above it are zero; digit 0 never is
   always_comb begin
      logic run;
      run     = bus.blank_lz;
      lz_mask = '0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         run        = run && (act_codes_q[5*i +: 5] == 5'd0);
         lz_mask[i] = run;
      end
   end

   // Pick the code, dp, suppression and blink state of the digit being scanned
   always_comb begin
      cur_code  = act_codes_q[4:0];
      cur_dp    = act_dp_q[0];
      cur_lz    = 1'b0;
      cur_blink = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (s_q == SW'(i)) begin
            cur_code  = act_codes_q[5*i +: 5];
            cur_dp    = act_dp_q[i];
            cur_lz    = lz_mask[i];
            cur_blink = phase_q && bus.blink_mask[i];
         end
      end
   end

   seg7_glyph u_glyph (
      .code_i  (cur_code),
      .glyph_o (glyph)
   );

   // Next outputs: PWM window skips p=0 as a guard against ghosting between digits
   always_comb begin
      enable_d = '0;
      if ((p_q != '0) && (p_q[3:0] <= bus.brightness)) begin
         enable_d = EN_ONE << s_q;
      end
      seg_d = (cur_lz || cur_blink) ? SEG_BLANK : glyph;
      dp_d  = cur_blink ? 1'b0 : cur_dp;
   end

   // Scan counters, blink phase and the tear-free double buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         p_q          <= '0;
         s_q          <= '0;
         blink_cnt_q  <= '0;
         phase_q      <= 1'b0;
         pend_v_q     <= 1'b0;
         pend_codes_q <= {N_DIGITS{CODE_BLANK}};
         pend_dp_q    <= '0;
         act_codes_q  <= {N_DIGITS{CODE_BLANK}};
         act_dp_q     <= '0;
      end else begin
         if (p_q == P_LAST) begin
            p_q <= '0;
            s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
         end else begin
            p_q <= p_q + 1'b1;
         end

         if (boundary) begin
            if (blink_cnt_q == B_LAST) begin
               blink_cnt_q <= '0;
               phase_q     <= ~phase_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + 1'b1;
            end
         end

         // A load landing on the boundary goes straight to active and wins over pending
         if (bus.load && boundary) begin
            act_codes_q <= bus.digits;
            act_dp_q    <= bus.dp;
            pend_v_q    <= 1'b0;
         end else begin
            if (boundary && pend_v_q) begin
               act_codes_q <= pend_codes_q;
               act_dp_q    <= pend_dp_q;
               pend_v_q    <= 1'b0;
            end
            if (bus.load) begin
               pend_codes_q <= bus.digits;
               pend_dp_q    <= bus.dp;
               pend_v_q     <= 1'b1;
            end
         end
      end
   end

   // Output register: pins reflect the scan state of the previous cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q <= '0;
         seg_q    <= '0;
         dp_q     <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         enable_q <= enable_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         tick_q   <= boundary;
      end
   end

   assign bus.enable     = enable_q;
   assign bus.segmentos  = seg_q;
   assign bus.dp_out     = dp_q;
   assign bus.frame_tick = tick_q;

endmodule
